// File: rtl/branch_redirect_if.sv
// branch_redirect_if: execute-stage control-transfer request, fetch redirect handshake and status
interface branch_redirect_if #(
    parameter int XLEN       = 32,
    parameter int STAT_WIDTH = 32
);
    logic                  i_Valid;
    logic                  i_Is_Branch;
    logic                  i_Is_Jal;
    logic                  i_Is_Jalr;
    logic                  i_Compare_Result;
    logic [XLEN-1:0]       i_PC;
    logic [XLEN-1:0]       i_Immediate;
    logic [XLEN-1:0]       i_Rs1_Data;
    logic                  i_Predicted_Taken;
    logic [XLEN-1:0]       i_Predicted_Target;
    logic                  i_Fetch_Ready;
    logic                  o_Busy;
    logic                  o_Redirect_Valid;
    logic [XLEN-1:0]       o_Redirect_PC;
    logic                  o_Flush;
    logic [XLEN-1:0]       o_Link_Address;
    logic                  o_Misaligned;
    logic [STAT_WIDTH-1:0] o_Stat_Branches;
    logic [STAT_WIDTH-1:0] o_Stat_Mispredicts;

    modport master (
        output i_Valid, i_Is_Branch, i_Is_Jal, i_Is_Jalr, i_Compare_Result, i_PC,
               i_Immediate, i_Rs1_Data, i_Predicted_Taken, i_Predicted_Target, i_Fetch_Ready,
        input  o_Busy, o_Redirect_Valid, o_Redirect_PC, o_Flush, o_Link_Address,
               o_Misaligned, o_Stat_Branches, o_Stat_Mispredicts
    );

    modport slave (
        input  i_Valid, i_Is_Branch, i_Is_Jal, i_Is_Jalr, i_Compare_Result, i_PC,
               i_Immediate, i_Rs1_Data, i_Predicted_Taken, i_Predicted_Target, i_Fetch_Ready,
        output o_Busy, o_Redirect_Valid, o_Redirect_PC, o_Flush, o_Link_Address,
               o_Misaligned, o_Stat_Branches, o_Stat_Mispredicts
    );
endinterface

// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: resolves branches/jumps, redirects fetch on mispredict; BRANCH_STATS_EN adds counters
module branch_redirect_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int STAT_WIDTH   = 32
) (
    input logic               i_Clock,
    input logic               i_Reset_N,
    branch_redirect_if.slave  bus
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [XLEN-1:0] r_redirect_pc;
    logic [XLEN-1:0] r_link;
    logic            r_misaligned;
    logic            w_accept;
    logic            w_taken;
    logic [XLEN-1:0] w_link;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_next;
    logic            w_misaligned;
    logic            w_mispredict;
    logic            w_redirect;

    // Resolve the presented transfer: decision, target, prediction check
    always_comb begin
        w_accept     = bus.i_Valid & (r_state == IDLE) & (bus.i_Is_Branch | bus.i_Is_Jal | bus.i_Is_Jalr);
        w_taken      = bus.i_Is_Jal | bus.i_Is_Jalr | (bus.i_Is_Branch & bus.i_Compare_Result);
        w_link       = bus.i_PC + XLEN'(4);
        w_target     = bus.i_Is_Jalr ? ((bus.i_Rs1_Data + bus.i_Immediate) & ~XLEN'(1))
                                     : (bus.i_PC + bus.i_Immediate);
        w_next       = w_taken ? w_target : w_link;
        w_misaligned = w_taken & w_target[1];
        w_mispredict = (w_taken != bus.i_Predicted_Taken) |
                       (w_taken & (bus.i_Predicted_Target != w_target));
        w_redirect   = w_accept & ~w_misaligned & w_mispredict;
    end

    // Next-state logic: hold redirect until fetch accepts, then count out the flush window
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        unique case (r_state)
            IDLE:     w_state_nxt = w_redirect ? REDIRECT : IDLE;
            REDIRECT: if (bus.i_Fetch_Ready) begin
                          w_state_nxt = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
                          w_count_nxt = CW'(FLUSH_CYCLES);
                      end
            FLUSH:    if (r_count <= CW'(1)) begin
                          w_state_nxt = IDLE;
                          w_count_nxt = '0;
                      end else begin
                          w_count_nxt = r_count - CW'(1);
                      end
            default:  w_state_nxt = IDLE;
        endcase
    end

    // State, flush counter and registered outputs
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_redirect_pc <= '0;
            r_link        <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_redirect_pc <= w_redirect ? w_next : r_redirect_pc;
            r_link        <= w_accept ? w_link : r_link;
            r_misaligned  <= w_accept & w_misaligned;
        end
    end

    assign bus.o_Busy           = (r_state != IDLE);
    assign bus.o_Flush          = (r_state != IDLE);
    assign bus.o_Redirect_Valid = (r_state == REDIRECT);
    assign bus.o_Redirect_PC    = r_redirect_pc;
    assign bus.o_Link_Address   = r_link;
    assign bus.o_Misaligned     = r_misaligned;

`ifdef BRANCH_STATS_EN
    logic [STAT_WIDTH-1:0] r_stat_branches;
    logic [STAT_WIDTH-1:0] r_stat_mispredicts;

    // Count resolved transfers and redirects issued, wrapping naturally
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            r_stat_branches    <= r_stat_branches + STAT_WIDTH'(w_accept);
            r_stat_mispredicts <= r_stat_mispredicts + STAT_WIDTH'(w_redirect);
        end
    end

    assign bus.o_Stat_Branches    = r_stat_branches;
    assign bus.o_Stat_Mispredicts = r_stat_mispredicts;
`else
    assign bus.o_Stat_Branches    = '0;
    assign bus.o_Stat_Mispredicts = '0;
`endif
endmodule
